// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, assembles 1/2-byte instructions into the IF/ID register.
// Optional interrupt vector fetch is compiled in when IF_FETCH_INT_EN is defined.
module if_fetch_stage #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter logic [3:0] TWO_BYTE_OP  = 4'hC,
  parameter logic [7:0] INT_VEC_ADDR = 8'h01
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_imem_addr,
  input  logic [7:0] i_imem_data,
  input  logic       i_stall,
  input  logic       i_redirect_en,
  input  logic [7:0] i_redirect_pc,
  input  logic       i_int_sig,
  output logic       o_if_valid,
  output logic [7:0] o_if_instr,
  output logic [7:0] o_if_imm,
  output logic [7:0] o_if_pc,
  output logic [7:0] o_if_pc_next,
  output logic       o_if_int
);

  // state     | meaning
  // FETCH_OP  | address pc, read opcode byte
  // FETCH_IMM | address pc, read second byte of the latched 2-byte opcode
  // FETCH_VEC | address INT_VEC_ADDR, load pc from the interrupt vector
  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    FETCH_VEC = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic [7:0] r_op, w_op_nxt;
  logic [7:0] r_op_pc, w_op_pc_nxt;
  logic       r_valid, w_valid_nxt;
  logic [7:0] r_instr, w_instr_nxt;
  logic [7:0] r_imm, w_imm_nxt;
  logic [7:0] r_if_pc, w_if_pc_nxt;
  logic [7:0] r_if_pc_next, w_if_pc_next_nxt;
  logic       r_if_int, w_if_int_nxt;
  logic [7:0] w_pc_inc;
  logic       w_take_int;

  assign w_pc_inc = r_pc + 8'd1;

`ifdef IF_FETCH_INT_EN
  logic r_int_d;
  logic r_pend;
  logic w_vec_done;

  assign w_vec_done = (r_state == FETCH_VEC) && !i_redirect_en && !i_stall;
  // Only consulted in FETCH_OP, so a 2-byte instruction is never split.
  assign w_take_int = r_pend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_int_d <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_int_d <= i_int_sig;
      if (i_int_sig && !r_int_d) begin
        r_pend <= 1'b1;
      end else if (w_vec_done) begin
        r_pend <= 1'b0;
      end
    end
  end
`else
  logic w_unused_int;
  assign w_unused_int = i_int_sig;
  assign w_take_int   = 1'b0;
`endif

  assign o_imem_addr = (r_state == FETCH_VEC) ? INT_VEC_ADDR : r_pc;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_op_nxt         = r_op;
    w_op_pc_nxt      = r_op_pc;
    w_valid_nxt      = r_valid;
    w_instr_nxt      = r_instr;
    w_imm_nxt        = r_imm;
    w_if_pc_nxt      = r_if_pc;
    w_if_pc_next_nxt = r_if_pc_next;
    w_if_int_nxt     = r_if_int;
    if (i_redirect_en) begin
      w_pc_nxt    = i_redirect_pc;
      w_state_nxt = FETCH_OP;
      w_valid_nxt = 1'b0;
    end else if (!i_stall) begin
      case (r_state)
        FETCH_OP: begin
          if (w_take_int) begin
            w_state_nxt = FETCH_VEC;
            w_valid_nxt = 1'b0;
          end else if (i_imem_data[7:4] == TWO_BYTE_OP) begin
            w_op_nxt    = i_imem_data;
            w_op_pc_nxt = r_pc;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = FETCH_IMM;
            w_valid_nxt = 1'b0;
          end else begin
            w_valid_nxt      = 1'b1;
            w_instr_nxt      = i_imem_data;
            w_imm_nxt        = 8'h00;
            w_if_pc_nxt      = r_pc;
            w_if_pc_next_nxt = w_pc_inc;
            w_if_int_nxt     = 1'b0;
            w_pc_nxt         = w_pc_inc;
          end
        end
        FETCH_IMM: begin
          w_valid_nxt      = 1'b1;
          w_instr_nxt      = r_op;
          w_imm_nxt        = i_imem_data;
          w_if_pc_nxt      = r_op_pc;
          w_if_pc_next_nxt = w_pc_inc;
          w_if_int_nxt     = 1'b0;
          w_pc_nxt         = w_pc_inc;
          w_state_nxt      = FETCH_OP;
        end
        FETCH_VEC: begin
          // The interrupted pc is both the entry address and the return address.
          w_valid_nxt      = 1'b1;
          w_instr_nxt      = 8'h00;
          w_imm_nxt        = 8'h00;
          w_if_pc_nxt      = r_pc;
          w_if_pc_next_nxt = r_pc;
          w_if_int_nxt     = 1'b1;
          w_pc_nxt         = i_imem_data;
          w_state_nxt      = FETCH_OP;
        end
        default: begin
          w_state_nxt = FETCH_OP;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= FETCH_OP;
      r_pc         <= RESET_PC;
      r_op         <= 8'h00;
      r_op_pc      <= 8'h00;
      r_valid      <= 1'b0;
      r_instr      <= 8'h00;
      r_imm        <= 8'h00;
      r_if_pc      <= 8'h00;
      r_if_pc_next <= 8'h00;
      r_if_int     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_op         <= w_op_nxt;
      r_op_pc      <= w_op_pc_nxt;
      r_valid      <= w_valid_nxt;
      r_instr      <= w_instr_nxt;
      r_imm        <= w_imm_nxt;
      r_if_pc      <= w_if_pc_nxt;
      r_if_pc_next <= w_if_pc_next_nxt;
      r_if_int     <= w_if_int_nxt;
    end
  end

  assign o_if_valid   = r_valid;
  assign o_if_instr   = r_instr;
  assign o_if_imm     = r_imm;
  assign o_if_pc      = r_if_pc;
  assign o_if_pc_next = r_if_pc_next;
  assign o_if_int     = r_if_int;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, corner sequences, randomized stream vs. memory-walk model.
module tb_if_fetch_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       stall;
  logic       redirect_en;
  logic [7:0] redirect_pc;
  logic       int_sig;
  logic       if_valid;
  logic [7:0] if_instr;
  logic [7:0] if_imm;
  logic [7:0] if_pc;
  logic [7:0] if_pc_next;
  logic       if_int;

  logic [7:0] mem [256];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  if_fetch_stage dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_addr   (imem_addr),
    .i_imem_data   (imem_data),
    .i_stall       (stall),
    .i_redirect_en (redirect_en),
    .i_redirect_pc (redirect_pc),
    .i_int_sig     (int_sig),
    .o_if_valid    (if_valid),
    .o_if_instr    (if_instr),
    .o_if_imm      (if_imm),
    .o_if_pc       (if_pc),
    .o_if_pc_next  (if_pc_next),
    .o_if_int      (if_int)
  );

  typedef struct {
    logic       s;
    logic       r;
    logic [7:0] rpc;
    logic       v;
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc;
    logic [7:0] pcn;
    logic [7:0] addr;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic s, input logic r, input logic [7:0] rpc,
                              input logic v, input logic [7:0] instr, input logic [7:0] imm,
                              input logic [7:0] pc, input logic [7:0] pcn, input logic [7:0] addr);
    vec_t e;
    e.s = s; e.r = r; e.rpc = rpc; e.v = v; e.instr = instr;
    e.imm = imm; e.pc = pc; e.pcn = pcn; e.addr = addr;
    return e;
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [7:0] instr,
                           input logic [7:0] imm, input logic [7:0] pc, input logic [7:0] pcn,
                           input logic intf);
    chk8({name, ".valid"}, {7'd0, if_valid}, {7'd0, v});
    chk8({name, ".instr"}, if_instr, instr);
    chk8({name, ".imm"}, if_imm, imm);
    chk8({name, ".pc"}, if_pc, pc);
    chk8({name, ".pc_next"}, if_pc_next, pcn);
    chk8({name, ".int"}, {7'd0, if_int}, {7'd0, intf});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 8'h00; int_sig = 1'b0;
    step();
    step();
    check_out("reset", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk8("reset.addr", imem_addr, 8'h00);
    rst = 1'b0;
  endtask

  // Reference: the instruction that starts at address p, by the byte-format rules alone.
  task automatic peek(input logic [7:0] p, output logic [7:0] instr, output logic [7:0] imm,
                      output logic [7:0] pcn, output logic [7:0] len);
    logic [7:0] p1;
    p1 = p + 8'd1;
    instr = mem[p];
    if (instr[7:4] == 4'hC) begin
      imm = mem[p1]; pcn = p + 8'd2; len = 8'd2;
    end else begin
      imm = 8'h00; pcn = p1; len = 8'd1;
    end
  endtask

  initial begin
    logic [7:0] walk, cnt, e_instr, e_imm, e_pcn, e_len, rp;
    logic       s_c, r_c, p_v, p_int;
    logic [7:0] p_instr, p_imm, p_pc, p_pcn;

    // Directed table: 2-byte assembly, 1-byte stream, stall in FETCH_IMM, redirect, redirect beats stall.
    clear_mem();
    mem[0] = 8'hC5; mem[1] = 8'hF0; mem[2] = 8'h00; mem[3] = 8'h10; mem[4] = 8'h20;
    mem[5] = 8'h30; mem[6] = 8'hC5; mem[7] = 8'hF0; mem[8] = 8'hC5; mem[9] = 8'hF0;
    mem[8'h40] = 8'h77;
    tbl[0]  = mk(0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    tbl[1]  = mk(0, 0, 8'h00, 1, 8'hC5, 8'hF0, 8'h00, 8'h02, 8'h02);
    tbl[2]  = mk(0, 0, 8'h00, 1, 8'h00, 8'h00, 8'h02, 8'h03, 8'h03);
    tbl[3]  = mk(0, 0, 8'h00, 1, 8'h10, 8'h00, 8'h03, 8'h04, 8'h04);
    tbl[4]  = mk(0, 0, 8'h00, 1, 8'h20, 8'h00, 8'h04, 8'h05, 8'h05);
    tbl[5]  = mk(0, 0, 8'h00, 1, 8'h30, 8'h00, 8'h05, 8'h06, 8'h06);
    tbl[6]  = mk(0, 0, 8'h00, 0, 8'h30, 8'h00, 8'h05, 8'h06, 8'h07);
    tbl[7]  = mk(1, 0, 8'h00, 0, 8'h30, 8'h00, 8'h05, 8'h06, 8'h07);
    tbl[8]  = mk(1, 0, 8'h00, 0, 8'h30, 8'h00, 8'h05, 8'h06, 8'h07);
    tbl[9]  = mk(1, 0, 8'h00, 0, 8'h30, 8'h00, 8'h05, 8'h06, 8'h07);
    tbl[10] = mk(0, 0, 8'h00, 1, 8'hC5, 8'hF0, 8'h06, 8'h08, 8'h08);
    tbl[11] = mk(0, 0, 8'h00, 0, 8'hC5, 8'hF0, 8'h06, 8'h08, 8'h09);
    tbl[12] = mk(0, 1, 8'h40, 0, 8'hC5, 8'hF0, 8'h06, 8'h08, 8'h40);
    tbl[13] = mk(0, 0, 8'h00, 1, 8'h77, 8'h00, 8'h40, 8'h41, 8'h41);
    tbl[14] = mk(1, 1, 8'h03, 0, 8'h77, 8'h00, 8'h40, 8'h41, 8'h03);
    tbl[15] = mk(0, 0, 8'h00, 1, 8'h10, 8'h00, 8'h03, 8'h04, 8'h04);
    tbl[16] = mk(1, 0, 8'h00, 1, 8'h10, 8'h00, 8'h03, 8'h04, 8'h04);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      stall = tbl[i].s; redirect_en = tbl[i].r; redirect_pc = tbl[i].rpc;
      step();
      check_out($sformatf("tbl%0d", i), tbl[i].v, tbl[i].instr, tbl[i].imm,
                tbl[i].pc, tbl[i].pcn, 1'b0);
      chk8($sformatf("tbl%0d.addr", i), imem_addr, tbl[i].addr);
    end
    stall = 1'b0; redirect_en = 1'b0;

    // Back-to-back 1-byte instructions straight out of reset.
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("stream%0d", i), 1'b1, mem[i], 8'h00, 8'(i), 8'(i + 1), 1'b0);
    end

    // PC wrap: 2-byte at FF takes imm from 00; 1-byte at FF returns to 00.
    clear_mem();
    mem[8'hFF] = 8'hC5; mem[0] = 8'hAA;
    do_reset();
    redirect_en = 1'b1; redirect_pc = 8'hFF;
    step();
    chk8("wrap2.redir_valid", {7'd0, if_valid}, 8'h00);
    redirect_en = 1'b0;
    step();
    chk8("wrap2.bubble", {7'd0, if_valid}, 8'h00);
    chk8("wrap2.addr", imem_addr, 8'h00);
    step();
    check_out("wrap2", 1'b1, 8'hC5, 8'hAA, 8'hFF, 8'h01, 1'b0);
    mem[8'hFF] = 8'h33;
    redirect_en = 1'b1; redirect_pc = 8'hFF;
    step();
    redirect_en = 1'b0;
    step();
    check_out("wrap1", 1'b1, 8'h33, 8'h00, 8'hFF, 8'h00, 1'b0);

    // Reset in FETCH_IMM discards the latched opcode.
    clear_mem();
    mem[0] = 8'hC5; mem[1] = 8'hF0;
    do_reset();
    step();
    chk8("midrst.addr_imm", imem_addr, 8'h01);
    rst = 1'b1; mem[0] = 8'h12;
    step();
    check_out("midrst", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk8("midrst.addr", imem_addr, 8'h00);
    rst = 1'b0;
    step();
    check_out("midrst.after", 1'b1, 8'h12, 8'h00, 8'h00, 8'h01, 1'b0);

    // Interrupt handling.
    clear_mem();
    mem[1] = 8'h80;
    for (int i = 3; i < 8; i++) mem[i] = 8'(8'h10 + i);
    mem[8'h80] = 8'h99; mem[8'h81] = 8'hC5; mem[8'h82] = 8'hF0; mem[8'h83] = 8'h21;
    do_reset();
    redirect_en = 1'b1; redirect_pc = 8'h03;
    step();
    redirect_en = 1'b0;
    step();
    check_out("int.i3", 1'b1, 8'h13, 8'h00, 8'h03, 8'h04, 1'b0);
    int_sig = 1'b1;
    step();
    check_out("int.i4", 1'b1, 8'h14, 8'h00, 8'h04, 8'h05, 1'b0);
    int_sig = 1'b0;
`ifdef IF_FETCH_INT_EN
    step();
    chk8("int.bubble", {7'd0, if_valid}, 8'h00);
    chk8("int.vec_addr", imem_addr, 8'h01);
    step();
    check_out("int.entry", 1'b1, 8'h00, 8'h00, 8'h05, 8'h05, 1'b1);
    step();
    check_out("int.resume", 1'b1, 8'h99, 8'h00, 8'h80, 8'h81, 1'b0);
    int_sig = 1'b1;
    step();
    chk8("int2.opc_bubble", {7'd0, if_valid}, 8'h00);
    int_sig = 1'b0;
    step();
    check_out("int2.c5", 1'b1, 8'hC5, 8'hF0, 8'h81, 8'h83, 1'b0);
    step();
    chk8("int2.bubble", {7'd0, if_valid}, 8'h00);
    step();
    check_out("int2.entry", 1'b1, 8'h00, 8'h00, 8'h83, 8'h83, 1'b1);
`else
    step();
    check_out("noint.i5", 1'b1, 8'h15, 8'h00, 8'h05, 8'h06, 1'b0);
`endif

    // Randomized stream against the memory-walk model.
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) mem[i] = {4'hC, 4'($urandom_range(0, 15))};
      else mem[i] = 8'($urandom_range(0, 255));
    end
    do_reset();
    walk = 8'h00; cnt = 8'h00;
    for (int it = 0; it < 3000; it++) begin
      s_c = ($urandom_range(0, 3) == 0);
      r_c = ($urandom_range(0, 11) == 0);
      rp  = 8'($urandom_range(0, 255));
      stall = s_c; redirect_en = r_c; redirect_pc = rp;
`ifndef IF_FETCH_INT_EN
      int_sig = 1'($urandom_range(0, 1));
`endif
      p_v = if_valid; p_instr = if_instr; p_imm = if_imm; p_pc = if_pc;
      p_pcn = if_pc_next; p_int = if_int;
      step();
      if (r_c) begin
        check_out("rand.redir", 1'b0, p_instr, p_imm, p_pc, p_pcn, p_int);
        walk = rp; cnt = 8'h00;
      end else if (s_c) begin
        check_out("rand.stall", p_v, p_instr, p_imm, p_pc, p_pcn, p_int);
      end else begin
        cnt = cnt + 8'd1;
        peek(walk, e_instr, e_imm, e_pcn, e_len);
        if (if_valid) begin
          check_out("rand.emit", 1'b1, e_instr, e_imm, walk, e_pcn, 1'b0);
          chk8("rand.latency", cnt, e_len);
          walk = e_pcn; cnt = 8'h00;
        end else begin
          chk8("rand.bubble", {7'd0, (cnt < e_len)}, 8'h01);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined CPU. It sits directly upstream of decode and owns the PC.
- It reads the byte-wide unified memory and assembles 1-byte or 2-byte instructions. Opcode 12 (LDM/LDD/STD) carries a second address/immediate byte.
- It presents each complete instruction in an internal IF/ID register.
- It honours decode stalls and execute-stage PC redirects (branch, jump, ret).

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- TWO_BYTE_OP, 4'hC, opcode (instr[7:4]) that marks a 2-byte instruction.
- INT_VEC_ADDR, 8'h01, memory address holding the interrupt vector (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_addr  out  8  memory read address (combinational from state/PC).
- imem_data  in  8  memory read data, combinational same-cycle read.
- stall  in  1  decode cannot accept; hold everything.
- redirect_en  in  1  load a new PC and flush.
- redirect_pc  in  8  target PC.
- int_sig  in  1  external interrupt request (level).
- if_valid  out  1  IF/ID holds a valid instruction.
- if_instr  out  8  opcode byte.
- if_imm  out  8  second byte (0 for 1-byte instructions).
- if_pc  out  8  address of the opcode byte.
- if_pc_next  out  8  address following the instruction (return address).
- if_int  out  1  the entry is an interrupt pseudo-instruction.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=FETCH_OP, int pending=0, all if_* outputs=0.
- imem_addr = pc in FETCH_OP and FETCH_IMM. In FETCH_VEC it is INT_VEC_ADDR.
- Priority each edge: rst > redirect_en > stall > normal.
- Redirect (any state):
  - pc=redirect_pc, state=FETCH_OP, if_valid=0, other if_* unchanged.
  - A half-fetched 2-byte instruction is discarded.
- Stall (no redirect): pc, state and all if_* hold.
- FETCH_OP, imem_data[7:4]!=TWO_BYTE_OP:
  - if_valid=1, if_instr=imem_data, if_imm=0, if_pc=pc, if_pc_next=pc+1, if_int=0.
  - pc=pc+1.
- FETCH_OP, two-byte opcode:
  - Latch opcode and its address internally; pc=pc+1; state=FETCH_IMM.
  - if_valid=0 (bubble).
- FETCH_IMM:
  - if_valid=1, if_instr=latched opcode, if_imm=imem_data, if_pc=latched address, if_pc_next=pc+1.
  - pc=pc+1; state=FETCH_OP.
- Latency: an instruction is visible on if_* one edge after its last byte is addressed.
  - 1-byte instructions: throughput of 1 per cycle.
  - 2-byte instructions: 1 per 2 cycles.
- Arithmetic: 8-bit PC wraps modulo 256.
  - 1-byte instruction at 0xFF gives if_pc_next=0x00.
  - 2-byte opcode at 0xFF takes its second byte from 0x00; if_pc_next=0x01.
- rst asserted mid 2-byte fetch: the latched opcode is discarded and the state returns to FETCH_OP.

Optional Feature:
- Macro IF_FETCH_INT_EN.
- Defined:
  - A rising int_sig sets pending.
  - In FETCH_OP, with no stall/redirect and pending=1, the opcode fetch is skipped and state=FETCH_VEC. pc is not advanced.
  - FETCH_VEC: imem_addr=INT_VEC_ADDR; pc=imem_data.
  - Emits if_valid=1, if_int=1, if_instr=0, if_imm=0, if_pc=if_pc_next=interrupted pc. Clears pending; state=FETCH_OP.
  - Redirect in FETCH_VEC aborts the vector fetch and keeps pending.
  - Interrupts never split a 2-byte instruction.
- Undefined:
  - int_sig is ignored, if_int is tied 0, and FETCH_VEC is unreachable.

Test Plan:
- mem[0]=C5, mem[1]=F0, mem[2]=00, release rst:
  - edge 1: if_valid=0.
  - edge 2: if_valid=1, if_instr=C5, if_imm=F0, if_pc=00, if_pc_next=02.
  - edge 3: if_instr=00, if_pc=02.
- mem[0..2]=10,20,30: consecutive edges give if_instr 10,20,30 with if_pc 0,1,2 and if_valid constantly 1.
- stall=1 for 3 cycles during FETCH_IMM of C5 F0: all if_* and PC frozen. After release, C5/F0 is emitted exactly once.
- redirect_en=1, redirect_pc=40 while in FETCH_IMM: next edge if_valid=0. The following edge emits mem[0x40] with if_pc=40 and no C5 entry.
- redirect_pc=FF, mem[FF]=C5, mem[00]=AA: if_imm=AA, if_pc=FF, if_pc_next=01.
- (IF_FETCH_INT_EN) mem[1]=80, int_sig pulse while executing 1-byte instructions at pc=05: one entry with if_int=1, if_pc_next=05, then fetch resumes at 0x80. A pulse during a C5 fetch is taken only after the imm byte is emitted.
